mem_byte_seq: RTL and testbench

- Multi-cycle sequencer between the decoded memory op (8-bit active-low one-hot: lb, lh, lw, lbu, lhu, sb, sh, sw) and an 8-bit-wide external memory bus.
- Splits each access into 1/2/4 little-endian byte cycles.
- Waits on a bus ready handshake, then assembles and extends load data.
- Holds the pipeline via a stall output until the access completes.

---
 rtl/mem_byte_seq_if.sv | 27 ++
 rtl/mem_byte_seq.sv | 215 +++++++++++++++++++++
 tb/tb_mem_byte_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_seq_if.sv
// Byte-wide external memory bus between mem_byte_seq (master) and the memory (slave).
interface mem_byte_seq_if;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_cs_n;
    logic        bus_we_n;
    logic        bus_ready;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_cs_n,
        output bus_we_n,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_cs_n,
        input  bus_we_n,
        output bus_rdata,
        output bus_ready
    );
endinterface

// File: rtl/mem_byte_seq.sv
// Sequences lb/lh/lw/lbu/lhu/sb/sh/sw into little-endian byte cycles on an 8-bit bus.
// Optional MEM_SEQ_TIMEOUT_EN aborts a byte that waits TIMEOUT cycles for bus_ready.
module mem_byte_seq #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     mem_op,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic           stall,
    output logic           done,
    output logic           err,
    output logic [31:0]    rdata,
    mem_byte_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_buf_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic        is_load_q;
    logic        is_signed_q;
    logic        err_q;

    logic [7:0]  op_n;
    logic        req;
    logic        one_hot;
    logic        dec_byte;
    logic        dec_half;
    logic        dec_word;
    logic        dec_load;
    logic        dec_signed;
    logic        dec_err;
    logic [1:0]  dec_last;

    logic [31:0] assembled;
    logic [31:0] extended;
    logic        timeout_hit;

    generate
        if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
            $error("mem_byte_seq: TIMEOUT must be in 1 .. 2**TO_W-1");
        end
    endgenerate

    // Bit order {lb,lh,lw,lbu,lhu,sb,sh,sw}, active low; anything but exactly one low bit is illegal.
    always_comb begin
        op_n       = ~mem_op;
        req        = (mem_op != 8'hFF);
        one_hot    = ((op_n & (op_n - 8'd1)) == 8'd0);
        dec_byte   = op_n[7] | op_n[4] | op_n[2];
        dec_half   = op_n[6] | op_n[3] | op_n[1];
        dec_word   = op_n[5] | op_n[0];
        dec_load   = |op_n[7:3];
        dec_signed = op_n[7] | op_n[6];
        dec_err    = !one_hot
                   | (dec_half & addr[0])
                   | (dec_word & (addr[1:0] != 2'b00));
        if (dec_word) begin
            dec_last = 2'd3;
        end else if (dec_half) begin
            dec_last = 2'd1;
        end else begin
            dec_last = 2'd0;
        end
        if (dec_byte && dec_half) begin
            dec_last = 2'd0;
        end
    end

    // The final byte lands in the same edge that loads rdata, so merge it in combinationally.
    always_comb begin
        assembled = load_buf_q;
        assembled[{idx_q, 3'b000} +: 8] = bus.bus_rdata;
        case (last_q)
            2'd0:    extended = is_signed_q ? {{24{assembled[7]}}, assembled[7:0]}
                                            : {24'd0, assembled[7:0]};
            2'd1:    extended = is_signed_q ? {{16{assembled[15]}}, assembled[15:0]}
                                            : {16'd0, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    // Counts consecutive not-ready cycles on the current byte; any completed byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || state_q != ACCESS || bus.bus_ready) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    always_comb begin
        timeout_hit = (state_q == ACCESS) && !bus.bus_ready
                    && (to_cnt_q == TO_W'(TIMEOUT - 1));
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        stall             = 1'b0;
        bus.bus_cs_n      = 1'b1;
        bus.bus_we_n      = 1'b1;
        bus.bus_addr      = 32'd0;
        bus.bus_wdata     = 8'd0;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    state_d = dec_err ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall         = 1'b1;
                bus.bus_cs_n  = 1'b0;
                bus.bus_we_n  = is_load_q;
                bus.bus_addr  = addr_q + {30'd0, idx_q};
                if (!is_load_q) begin
                    bus.bus_wdata = wdata_q[{idx_q, 3'b000} +: 8];
                end
                if (bus.bus_ready && (idx_q == last_q)) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        done = (state_q == DONE);
        err  = (state_q == DONE) && err_q;
    end

    // Request fields are captured only in IDLE, so upstream may change them once stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            load_buf_q  <= 32'd0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            is_load_q   <= 1'b0;
            is_signed_q <= 1'b0;
            err_q       <= 1'b0;
            rdata       <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        is_load_q   <= dec_load;
                        is_signed_q <= dec_signed;
                        last_q      <= dec_last;
                        err_q       <= dec_err;
                        idx_q       <= 2'd0;
                    end
                end
                ACCESS: begin
                    if (bus.bus_ready) begin
                        if (is_load_q) begin
                            load_buf_q[{idx_q, 3'b000} +: 8] <= bus.bus_rdata;
                        end
                        if (idx_q == last_q) begin
                            if (is_load_q) begin
                                rdata <= extended;
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed self-checking bench for mem_byte_seq; the timeout section follows MEM_SEQ_TIMEOUT_EN.
module tb_mem_byte_seq;

    localparam logic [7:0] OP_LB   = 8'h7F;
    localparam logic [7:0] OP_LW   = 8'hDF;
    localparam logic [7:0] OP_LBU  = 8'hEF;
    localparam logic [7:0] OP_LHU  = 8'hF7;
    localparam logic [7:0] OP_SH   = 8'hFD;
    localparam logic [7:0] OP_NONE = 8'hFF;
    localparam logic [7:0] OP_BAD  = 8'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_op = OP_NONE;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int done_seen;
    logic [7:0] lw_bytes [4];

    mem_byte_seq_if bus_if ();

    mem_byte_seq #(
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_op (mem_op),
        .addr   (addr),
        .wdata  (wdata),
        .stall  (stall),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic r, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic rdy, input logic [7:0] rd);
        @(negedge clk);
        rst              = r;
        mem_op           = op;
        addr             = a;
        wdata            = wd;
        bus_if.bus_ready = rdy;
        bus_if.bus_rdata = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 8'd0;

        // Reset state
        applyStimulus(1, OP_NONE, 0, 0, 0, 0);
        applyStimulus(1, OP_NONE, 0, 0, 0, 0);
        checkOutput("rst_cs_n",  32'(bus_if.bus_cs_n), 32'd1);
        checkOutput("rst_we_n",  32'(bus_if.bus_we_n), 32'd1);
        checkOutput("rst_done",  32'(done), 32'd0);
        checkOutput("rst_err",   32'(err), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_addr",  bus_if.bus_addr, 32'd0);
        checkOutput("rst_wdata", 32'(bus_if.bus_wdata), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

        // lw 0x100, ready high; addr is changed mid-access and must be ignored
        lw_bytes[0] = 8'h11; lw_bytes[1] = 8'h22; lw_bytes[2] = 8'h33; lw_bytes[3] = 8'h44;
        applyStimulus(0, OP_LW, 32'h100, 0, 1, 8'h00);
        checkOutput("lw_stall0", 32'(stall), 32'd1);
        checkOutput("lw_cs0",    32'(bus_if.bus_cs_n), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, OP_NONE, 32'hFFF, 0, 1, lw_bytes[k]);
            checkOutput("lw_addr",  bus_if.bus_addr, 32'h100 + 32'(k));
            checkOutput("lw_cs",    32'(bus_if.bus_cs_n), 32'd0);
            checkOutput("lw_we",    32'(bus_if.bus_we_n), 32'd1);
            checkOutput("lw_stall", 32'(stall), 32'd1);
            checkOutput("lw_nodone", 32'(done), 32'd0);
        end
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("lw_done",  32'(done), 32'd1);
        checkOutput("lw_err",   32'(err), 32'd0);
        checkOutput("lw_stallD", 32'(stall), 32'd0);
        checkOutput("lw_rdata", rdata, 32'h44332211);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("lw_idle_done", 32'(done), 32'd0);

        // lb then lbu of byte 0x80 at 0x203
        applyStimulus(0, OP_LB, 32'h203, 0, 1, 8'h80);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h80);
        checkOutput("lb_addr", bus_if.bus_addr, 32'h203);
        checkOutput("lb_nodone", 32'(done), 32'd0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h00);
        checkOutput("lb_done",  32'(done), 32'd1);
        checkOutput("lb_rdata", rdata, 32'hFFFFFF80);
        applyStimulus(0, OP_LBU, 32'h203, 0, 1, 8'h80);
        checkOutput("lbu_stall", 32'(stall), 32'd1);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h80);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h00);
        checkOutput("lbu_done",  32'(done), 32'd1);
        checkOutput("lbu_rdata", rdata, 32'h00000080);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

        // sh 0x10 with two wait cycles on byte 0
        applyStimulus(0, OP_SH, 32'h10, 32'hDEADBEEF, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, OP_NONE, 0, 0, (k == 2), 0);
            checkOutput("sh_addr0",  bus_if.bus_addr, 32'h10);
            checkOutput("sh_wdata0", 32'(bus_if.bus_wdata), 32'hEF);
            checkOutput("sh_we0",    32'(bus_if.bus_we_n), 32'd0);
            checkOutput("sh_cs0",    32'(bus_if.bus_cs_n), 32'd0);
        end
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("sh_addr1",  bus_if.bus_addr, 32'h11);
        checkOutput("sh_wdata1", 32'(bus_if.bus_wdata), 32'hBE);
        checkOutput("sh_nodone", 32'(done), 32'd0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("sh_done",  32'(done), 32'd1);
        checkOutput("sh_err",   32'(err), 32'd0);
        checkOutput("sh_rdata", rdata, 32'h00000080);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

        // Misaligned lw and an illegal two-hot op: no bus cycle, done+err at +1
        applyStimulus(0, OP_LW, 32'h102, 0, 1, 0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("mis_done",  32'(done), 32'd1);
        checkOutput("mis_err",   32'(err), 32'd1);
        checkOutput("mis_cs",    32'(bus_if.bus_cs_n), 32'd1);
        checkOutput("mis_rdata", rdata, 32'h00000080);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("mis_idle_err", 32'(err), 32'd0);
        applyStimulus(0, OP_BAD, 32'h0, 0, 1, 0);
        checkOutput("ill_cs0", 32'(bus_if.bus_cs_n), 32'd1);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("ill_done",  32'(done), 32'd1);
        checkOutput("ill_err",   32'(err), 32'd1);
        checkOutput("ill_cs",    32'(bus_if.bus_cs_n), 32'd1);
        checkOutput("ill_rdata", rdata, 32'h00000080);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

        // Reset during byte 2 of an lw aborts without done
        applyStimulus(0, OP_LW, 32'h40, 0, 1, 8'hAA);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'hAA);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'hBB);
        applyStimulus(1, OP_NONE, 0, 0, 1, 8'hCC);
        checkOutput("abort_addr2", bus_if.bus_addr, 32'h42);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("abort_cs",    32'(bus_if.bus_cs_n), 32'd1);
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_done",  32'(done), 32'd0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("abort_done2", 32'(done), 32'd0);

        // lhu 0x8001 at 0x20 after the abort
        applyStimulus(0, OP_LHU, 32'h20, 0, 1, 8'h01);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h01);
        checkOutput("lhu_addr0", bus_if.bus_addr, 32'h20);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h80);
        checkOutput("lhu_addr1", bus_if.bus_addr, 32'h21);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("lhu_done",  32'(done), 32'd1);
        checkOutput("lhu_rdata", rdata, 32'h00008001);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

`ifdef MEM_SEQ_TIMEOUT_EN
        // lw with ready stuck low gives up after 4 waiting cycles on byte 0
        applyStimulus(0, OP_LW, 32'h60, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, OP_NONE, 0, 0, 0, 0);
            checkOutput("to_cs",     32'(bus_if.bus_cs_n), 32'd0);
            checkOutput("to_nodone", 32'(done), 32'd0);
        end
        applyStimulus(0, OP_NONE, 0, 0, 0, 0);
        checkOutput("to_done",  32'(done), 32'd1);
        checkOutput("to_err",   32'(err), 32'd1);
        checkOutput("to_cs_rel", 32'(bus_if.bus_cs_n), 32'd1);
        checkOutput("to_rdata", rdata, 32'h00008001);
`else
        // Without the timeout an lb waits on bus_ready indefinitely
        done_seen = 0;
        applyStimulus(0, OP_LB, 32'h50, 0, 0, 8'h7F);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, OP_NONE, 0, 0, 0, 8'h7F);
            done_seen += int'(done);
        end
        checkOutput("wait_no_done", 32'(done_seen), 32'd0);
        checkOutput("wait_cs",      32'(bus_if.bus_cs_n), 32'd0);
        applyStimulus(0, OP_NONE, 0, 0, 1, 8'h7F);
        checkOutput("wait_addr", bus_if.bus_addr, 32'h50);
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);
        checkOutput("wait_done",  32'(done), 32'd1);
        checkOutput("wait_err",   32'(err), 32'd0);
        checkOutput("wait_rdata", rdata, 32'h0000007F);
`endif
        applyStimulus(0, OP_NONE, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
